// File: rtl/vga_pkg.sv
// Shared 640x480@60 VGA timing constants and the pixel-coordinate type
// used by the timing generator and the colour mapper.
package vga_pkg;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FP      = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BP      = 48;
  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FP      = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BP      = 33;

  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_VISIBLE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  localparam int unsigned COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  // Half-open window test: lo <= v < hi.
  function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up-counter with enable; exposes its next-state value so that
// decoders downstream can register against it on the same edge.
module mod_counter
  import vga_pkg::*;
#(
  parameter int unsigned MOD = H_TOTAL
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  output logic   wrap,
  output coord_t q,
  output coord_t nxt
);

  localparam coord_t LAST = coord_t'(MOD - 1);

  assign wrap = (q == LAST);

  // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
  always_comb begin
    nxt = q;
    if (en) nxt = wrap ? '0 : q + coord_t'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= nxt;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: Clk/2 pixel clock, hc/vc counters and registered,
// glitch-free sync/blank decodes plus a one-Clk frame_start pulse.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int unsigned H_FP      = vga_pkg::H_FP,
  parameter int unsigned H_SYNC    = vga_pkg::H_SYNC,
  parameter int unsigned H_BP      = vga_pkg::H_BP,
  parameter int unsigned V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int unsigned V_FP      = vga_pkg::V_FP,
  parameter int unsigned V_SYNC    = vga_pkg::V_SYNC,
  parameter int unsigned V_BP      = vga_pkg::V_BP
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       frame_start
);

  import vga_pkg::coord_t;
  import vga_pkg::in_window;

  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_VISIBLE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  localparam coord_t H_VIS_C = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS_C = coord_t'(V_VISIBLE);
  localparam coord_t HS_LO   = coord_t'(HS_START);
  localparam coord_t HS_HI   = coord_t'(HS_END);
  localparam coord_t VS_LO   = coord_t'(VS_START);
  localparam coord_t VS_HI   = coord_t'(VS_END);

  logic   ph;
  logic   hwrap, vwrap;
  coord_t hc, vc;
  coord_t h_nxt, v_nxt;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) ph <= 1'b0;
    else        ph <= ~ph;
  end

  mod_counter #(.MOD(H_TOTAL)) u_hcnt (
    .clk   (Clk),
    .rst_n (Reset),
    .en    (ph),
    .wrap  (hwrap),
    .q     (hc),
    .nxt   (h_nxt)
  );

  mod_counter #(.MOD(V_TOTAL)) u_vcnt (
    .clk   (Clk),
    .rst_n (Reset),
    .en    (ph & hwrap),
    .wrap  (vwrap),
    .q     (vc),
    .nxt   (v_nxt)
  );

  // Decodes are loaded from the counters' next state, so they switch on
  // the same edge as DrawX/DrawY and never see combinational glitches.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      VGA_HS      <= ~in_window(h_nxt, HS_LO, HS_HI);
      VGA_VS      <= ~in_window(v_nxt, VS_LO, VS_HI);
      VGA_BLANK_N <= (h_nxt < H_VIS_C) && (v_nxt < V_VIS_C);
      frame_start <= ph & hwrap & vwrap;
    end
  end

  assign VGA_CLK    = ph;
  assign VGA_SYNC_N = 1'b0;
  assign DrawX      = hc;
  assign DrawY      = vc;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: a default 640x480 instance and a tiny parameterised
// instance, both compared every Clk against an arithmetic raster model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst_d, rst_s;

  logic       vclk_d, hs_d, vs_d, bl_d, sn_d, fs_d;
  logic [9:0] x_d, y_d;
  logic       vclk_s, hs_s, vs_s, bl_s, sn_s, fs_s;
  logic [9:0] x_s, y_s;

  vga_timing_gen u_def (
    .Clk(clk), .Reset(rst_d), .VGA_CLK(vclk_d), .VGA_HS(hs_d), .VGA_VS(vs_d),
    .VGA_BLANK_N(bl_d), .VGA_SYNC_N(sn_d), .DrawX(x_d), .DrawY(y_d),
    .frame_start(fs_d)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_sml (
    .Clk(clk), .Reset(rst_s), .VGA_CLK(vclk_s), .VGA_HS(hs_s), .VGA_VS(vs_s),
    .VGA_BLANK_N(bl_s), .VGA_SYNC_N(sn_s), .DrawX(x_s), .DrawY(y_s),
    .frame_start(fs_s)
  );

  // Packed view {VGA_CLK, HS, VS, BLANK_N, SYNC_N, DrawX, DrawY, frame_start}.
  logic [25:0] obs_d, obs_s;
  assign obs_d = {vclk_d, hs_d, vs_d, bl_d, sn_d, x_d, y_d, fs_d};
  assign obs_s = {vclk_s, hs_s, vs_s, bl_s, sn_s, x_s, y_s, fs_s};

  localparam logic [25:0] RST_VEC = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0};

  int errors = 0;
  int checks = 0;

  // Clk edges seen since each reset was last released.
  longint kd = 0, ks = 0;
  always @(posedge clk or negedge rst_d) if (!rst_d) kd <= 0; else kd <= kd + 1;
  always @(posedge clk or negedge rst_s) if (!rst_s) ks <= 0; else ks <= ks + 1;

  // Raster model: after k edges, k/2 pixels have elapsed since (0,0).
  function automatic logic [25:0] model(longint k, int hv, int hf, int hsw, int hb,
                                        int vv, int vf, int vsw, int vb);
    longint ht = hv + hf + hsw + hb;
    longint vt = vv + vf + vsw + vb;
    longint p  = k / 2;
    longint hc = p % ht;
    longint vc = (p / ht) % vt;
    logic clk_e = (k % 2) == 1;
    logic hs_e  = !(hc >= hv + hf && hc < hv + hf + hsw);
    logic vs_e  = !(vc >= vv + vf && vc < vv + vf + vsw);
    logic bl_e  = (hc < hv) && (vc < vv);
    logic fs_e  = (k > 0) && (k % 2 == 0) && (p % (ht * vt) == 0);
    return {clk_e, hs_e, vs_e, bl_e, 1'b0, 10'(hc), 10'(vc), fs_e};
  endfunction

  function automatic logic [25:0] exp_d(longint k);
    return model(k, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction

  function automatic logic [25:0] exp_s(longint k);
    return model(k, 8, 2, 2, 2, 4, 1, 1, 1);
  endfunction

  task automatic test_reset();
    rst_d = 1'b0;
    rst_s = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (obs_d !== RST_VEC) begin
      errors++; $display("FAIL reset_def got=%h exp=%h", obs_d, RST_VEC);
    end
    checks++;
    if (obs_s !== RST_VEC) begin
      errors++; $display("FAIL reset_sml got=%h exp=%h", obs_s, RST_VEC);
    end
    rst_d = 1'b1;
    rst_s = 1'b1;
    @(negedge clk);
    checks++;
    if ({vclk_d, x_d, vclk_s, x_s} !== {1'b1, 10'd0, 1'b1, 10'd0}) begin
      errors++;
      $display("FAIL first_edge got clk=%b x=%0d clk_s=%b x_s=%0d exp clk=1 x=0",
               vclk_d, x_d, vclk_s, x_s);
    end
    @(negedge clk);
    checks++;
    if ({vclk_d, x_d, vclk_s, x_s} !== {1'b0, 10'd1, 1'b0, 10'd1}) begin
      errors++;
      $display("FAIL second_edge got clk=%b x=%0d clk_s=%b x_s=%0d exp clk=0 x=1",
               vclk_d, x_d, vclk_s, x_s);
    end
  endtask

  task automatic test_line();
    longint fall_k = -1, rise_k = -1, bfall_k = -1, wrap1 = -1, wrap2 = -1;
    int hs_low = 0;
    logic prev_hs, prev_bl;
    logic [9:0] prev_x;
    prev_hs = hs_d; prev_bl = bl_d; prev_x = x_d;
    while (kd < 3300) begin
      @(negedge clk);
      checks++;
      if (obs_d !== exp_d(kd)) begin
        errors++; $display("FAIL line_cycle k=%0d got=%h exp=%h", kd, obs_d, exp_d(kd));
      end
      if (prev_hs && !hs_d && fall_k < 0) fall_k = kd;
      if (!prev_hs && hs_d && rise_k < 0) rise_k = kd;
      if (prev_bl && !bl_d && bfall_k < 0) bfall_k = kd;
      if (prev_x != 10'd0 && x_d == 10'd0) begin
        if (wrap1 < 0) wrap1 = kd;
        else if (wrap2 < 0) wrap2 = kd;
      end
      if (wrap1 >= 0 && wrap2 < 0 && !hs_d) hs_low++;
      prev_hs = hs_d; prev_bl = bl_d; prev_x = x_d;
    end
    checks++;
    if (fall_k != 2 * 656) begin
      errors++; $display("FAIL hs_fall got k=%0d exp k=%0d", fall_k, 2 * 656);
    end
    checks++;
    if (rise_k != 2 * 752) begin
      errors++; $display("FAIL hs_rise got k=%0d exp k=%0d", rise_k, 2 * 752);
    end
    checks++;
    if (bfall_k != 2 * 640) begin
      errors++; $display("FAIL blank_fall got k=%0d exp k=%0d", bfall_k, 2 * 640);
    end
    checks++;
    if (wrap1 != 1600 || wrap2 - wrap1 != 1600) begin
      errors++; $display("FAIL line_len got wrap1=%0d wrap2=%0d exp 1600 3200", wrap1, wrap2);
    end
    checks++;
    if (hs_low != 192) begin
      errors++; $display("FAIL hs_width got=%0d exp=192", hs_low);
    end
  endtask

  task automatic test_frame_small();
    int fs_cnt = 0, vs_low = 0, dbl = 0, budget = 0;
    longint last_fs = -1, per = -1;
    logic prev_fs;
    while (fs_s !== 1'b1 && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (fs_s !== 1'b1) begin
      errors++; $display("FAIL frame_start_seen got=%b exp=1 within 400 Clk", fs_s);
    end
    prev_fs = 1'b0;
    for (int i = 0; i < 3 * 196; i++) begin
      checks++;
      if (obs_s !== exp_s(ks)) begin
        errors++; $display("FAIL frame_cycle k=%0d got=%h exp=%h", ks, obs_s, exp_s(ks));
      end
      if (fs_s) begin
        fs_cnt++;
        if (prev_fs) dbl++;
        if (last_fs >= 0) per = ks - last_fs;
        last_fs = ks;
        checks++;
        if ({x_s, y_s, bl_s} !== {10'd0, 10'd0, 1'b1}) begin
          errors++;
          $display("FAIL wrap_state got x=%0d y=%0d blank_n=%b exp 0 0 1", x_s, y_s, bl_s);
        end
      end
      if (!vs_s) vs_low++;
      prev_fs = fs_s;
      @(negedge clk);
    end
    checks++;
    if (fs_cnt != 3 || dbl != 0) begin
      errors++; $display("FAIL fs_pulses got=%0d wide=%0d exp=3 wide=0", fs_cnt, dbl);
    end
    checks++;
    if (per != 196) begin
      errors++; $display("FAIL frame_period got=%0d exp=196", per);
    end
    checks++;
    if (vs_low != 3 * 28) begin
      errors++; $display("FAIL vs_width got=%0d exp=%0d", vs_low, 3 * 28);
    end
  endtask

  task automatic test_mid_reset();
    rst_d = 1'b0;
    repeat (2) @(negedge clk);
    rst_d = 1'b1;
    while (kd < 2 * (800 + 300)) begin
      @(negedge clk);
      checks++;
      if (obs_d !== exp_d(kd)) begin
        errors++; $display("FAIL pre_reset k=%0d got=%h exp=%h", kd, obs_d, exp_d(kd));
      end
    end
    checks++;
    if ({x_d, y_d} !== {10'd300, 10'd1}) begin
      errors++; $display("FAIL mid_pos got x=%0d y=%0d exp 300 1", x_d, y_d);
    end
    @(posedge clk);
    #3 rst_d = 1'b0;
    #1;
    checks++;
    if (obs_d !== RST_VEC) begin
      errors++; $display("FAIL async_reset got=%h exp=%h", obs_d, RST_VEC);
    end
    repeat (3) @(negedge clk);
    rst_d = 1'b1;
    repeat (20) begin
      @(negedge clk);
      checks++;
      if (obs_d !== exp_d(kd)) begin
        errors++; $display("FAIL restart k=%0d got=%h exp=%h", kd, obs_d, exp_d(kd));
      end
    end
  endtask

  task automatic test_random_reset();
    for (int it = 0; it < 8; it++) begin
      int run_d = int'($urandom_range(5, 400));
      int run_s = int'($urandom_range(5, 400));
      int off   = int'($urandom_range(1, 8));
      int hold  = int'($urandom_range(1, 4));
      repeat (run_d) begin
        @(negedge clk);
        checks++;
        if (obs_d !== exp_d(kd)) begin
          errors++; $display("FAIL rand_def k=%0d got=%h exp=%h", kd, obs_d, exp_d(kd));
        end
      end
      @(posedge clk);
      #(off) rst_d = 1'b0;
      #1;
      checks++;
      if (obs_d !== RST_VEC) begin
        errors++; $display("FAIL rand_rst_def got=%h exp=%h", obs_d, RST_VEC);
      end
      repeat (hold) @(negedge clk);
      rst_d = 1'b1;
      repeat (run_s) begin
        @(negedge clk);
        checks++;
        if (obs_s !== exp_s(ks)) begin
          errors++; $display("FAIL rand_sml k=%0d got=%h exp=%h", ks, obs_s, exp_s(ks));
        end
      end
      @(posedge clk);
      #(off) rst_s = 1'b0;
      #1;
      checks++;
      if (obs_s !== RST_VEC) begin
        errors++; $display("FAIL rand_rst_sml got=%h exp=%h", obs_s, RST_VEC);
      end
      repeat (hold) @(negedge clk);
      rst_s = 1'b1;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_line();
    test_frame_small();
    test_mid_reset();
    test_random_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

- Generates 640x480 @ 60 Hz VGA timing from the 50 MHz system clock.
- Supplies the DrawX/DrawY pixel coordinates that the colour mapper consumes combinationally to produce VGA_R/G/B.
- Drives the sync, blank and pixel-clock pins that accompany that colour data to the DAC.
- Sits at the top level between the clock source and the colour mapper, beside the VGA pin drivers.

## Interface
Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels); line total = 800
- V_VISIBLE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines); frame total = 525

Ports:
- Clk  in  1  50 MHz system clock; single clock domain
- Reset  in  1  asynchronous, active-low reset
- VGA_CLK  out  1  pixel clock, Clk/2 (25 MHz)
- VGA_HS  out  1  horizontal sync, active-low
- VGA_VS  out  1  vertical sync, active-low
- VGA_BLANK_N  out  1  high inside the visible 640x480 region
- VGA_SYNC_N  out  1  constant 0; composite sync is unused
- DrawX  out  10  horizontal counter hc, 0..799
- DrawY  out  10  vertical counter vc, 0..524
- frame_start  out  1  one-Clk pulse when the counters wrap to (0,0)

## Operation
- Phase register ph toggles every Clk. VGA_CLK = ph.
- Counters advance on a Clk rising edge only when ph==1. Each pixel therefore lasts exactly 2 Clk cycles.
- hc counts 0..H_TOTAL-1, then wraps to 0.
- On each hc wrap, vc increments; at V_TOTAL-1 it wraps to 0.
- Decoded outputs use only registered counters; all compares are unsigned 10-bit:
  - VGA_HS = 0 iff H_VISIBLE+H_FP <= hc < H_VISIBLE+H_FP+H_SYNC (656..751).
  - VGA_VS = 0 iff V_VISIBLE+V_FP <= vc < V_VISIBLE+V_FP+V_SYNC (490..491).
  - VGA_BLANK_N = 1 iff hc < H_VISIBLE and vc < V_VISIBLE.
- HS, VS and BLANK_N are registers loaded from the next-state counter values. They therefore change on the same Clk edge as DrawX/DrawY and stay glitch-free.
- DrawX/DrawY are raw counters and are meaningful outside the visible area. Downstream logic must gate on VGA_BLANK_N.
- frame_start goes high for exactly one Clk cycle: the cycle after the edge where (hc,vc) moved from (799,524) to (0,0).
- frame_start does not assert on reset release.

## Timing
Reset values (asynchronous on Reset low, held while low):
- ph = 0, VGA_CLK = 0
- hc = 0, vc = 0
- VGA_HS = 1, VGA_VS = 1, VGA_BLANK_N = 1
- frame_start = 0

Cycle behaviour:
- First counter advance is the second Clk rising edge after Reset deasserts. The edge with ph=0 only toggles ph.
- Counter updates coincide with VGA_CLK going 1->0. The DAC samples colour on VGA_CLK rising edges, mid-pixel.
- Latency from counter change to HS/VS/BLANK_N change is 0 Clk (same edge).
- Colour-mapper output is valid one combinational path after DrawX/DrawY change.

Durations:
- Line = 1600 Clk; frame = 840,000 Clk.
- HS low for 192 Clk per line.
- VS low for 2 full lines (3200 Clk), starting at hc=0 of line 490.

Boundary conditions:
- Simultaneous hc wrap and vc wrap: both counters go to 0 on the same edge, and frame_start fires.
- Reset asserted mid-frame returns everything to reset values immediately. No partial-line completion is required.

## Structure
- Package vga_pkg holds:
  - the timing constants above;
  - derived localparams H_TOTAL, V_TOTAL, HS_START, HS_END, VS_START, VS_END;
  - a 10-bit coord_t typedef shared with the colour mapper.
- One sub-module is natural: mod_counter (parameter MOD; ports en, wrap, q), instantiated twice.
  - Horizontal instance: en = ph.
  - Vertical instance: en = ph & hwrap.
- Sync, blank and frame_start registers live in the top module.

## Test plan
- Reset low for 5 Clk, then release -> VGA_CLK, hc and vc are 0, HS/VS/BLANK_N are 1; the first increment of hc is at the 2nd rising edge after release.
- Run one line -> HS falls on the edge where hc becomes 656 and rises where hc becomes 752; BLANK_N falls at hc=640; line length is 1600 Clk.
- Run one frame -> VS is low exactly while vc ∈ {490,491}; BLANK_N stays 0 for all of vc 480..524; frame period is 840,000 Clk.
- Wrap (799,524)->(0,0) -> frame_start is high for exactly 1 Clk and BLANK_N returns to 1 on the same edge.
- Assert Reset at (hc=300, vc=200) between Clk edges -> all outputs take reset values without waiting for a Clk edge; after release, counting restarts from (0,0).
- Parameter override (H_VISIBLE=8, H_FP=2, H_SYNC=2, H_BP=2, V_VISIBLE=4, V_FP=1, V_SYNC=1, V_BP=1) -> line = 14 pixels, frame = 7 lines, and the HS/VS windows shift accordingly.
